// File: rtl/key_event_gen.sv
// key_event_gen
//   Converts a clean, debounced pushbutton level into single-cycle event
//   pulses (press, release, short press, long press, auto-repeat) plus a
//   "held" level. Intended to sit between the debouncer and the up/down
//   counter control so a held button steps the value repeatedly.
//
// Parameters
//   LONG_CYCLES    clocks from press_pulse to long_pulse (>= 2)
//   REPEAT_CYCLES  clocks between successive repeat pulses (>= 1)
//   REPEAT_EN      1 = auto-repeat enabled, 0 = repeat_pulse never fires
//
// Ports
//   clk            system clock, everything on posedge
//   rst_a_n        asynchronous reset, active low
//   key_in         debounced key level, synchronous to clk, 1 = pressed
//   press_pulse    1-cycle pulse on key press
//   release_pulse  1-cycle pulse on key release
//   short_pulse    1-cycle pulse on a release that precedes long_pulse
//   long_pulse     1-cycle pulse LONG_CYCLES clocks after press_pulse
//   repeat_pulse   1-cycle pulse every REPEAT_CYCLES clocks after long_pulse
//   held           level, 1 while the key is considered pressed
module key_event_gen #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic key_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_VAL   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_VAL = CNT_W'(REPEAT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             prev_reg;

  logic press_next, release_next, short_next, long_next, repeat_next, held_next;

  // State, counter, key history and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= CNT_ZERO;
      prev_reg      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prev_reg      <= key_in;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_pulse   <= short_next;
      long_pulse    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= held_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Require a rising edge so a key still down after release cannot
        // retrigger; prev clears on reset, so a key held through reset
        // still produces a press.
        if (key_in && !prev_reg) begin
          press_next = 1'b1;
          cnt_next   = CNT_ONE;
          state_next = PRESSED;
        end
      end

      PRESSED: begin
        // Release is checked first so it wins over a coincident long press.
        if (!key_in) begin
          release_next = 1'b1;
          short_next   = 1'b1;
          cnt_next     = CNT_ZERO;
          state_next   = IDLE;
        end else if (cnt_reg == LONG_VAL) begin
          long_next  = 1'b1;
          cnt_next   = CNT_ONE;
          state_next = HELD;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HELD: begin
        if (!key_in) begin
          release_next = 1'b1;
          cnt_next     = CNT_ZERO;
          state_next   = IDLE;
        end else if (REPEAT_EN && (cnt_reg == REPEAT_VAL)) begin
          repeat_next = 1'b1;
          cnt_next    = CNT_ONE;
        end else if (cnt_reg < REPEAT_VAL) begin
          // Saturate so a long hold with repeat disabled never wraps.
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase

    held_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

  localparam int LONG   = 8;
  localparam int REPEAT = 4;

  logic clk;
  logic rst_a_n;
  logic key_in;

  // Index 0: auto-repeat enabled, index 1: auto-repeat disabled.
  logic [1:0] press, rel, shrt, lng, rep, hld;

  int n_checks;
  int n_fail;

  key_event_gen #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT), .REPEAT_EN(1'b1)) dut_rep (
    .clk(clk), .rst_a_n(rst_a_n), .key_in(key_in),
    .press_pulse(press[0]), .release_pulse(rel[0]), .short_pulse(shrt[0]),
    .long_pulse(lng[0]), .repeat_pulse(rep[0]), .held(hld[0])
  );

  key_event_gen #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT), .REPEAT_EN(1'b0)) dut_norep (
    .clk(clk), .rst_a_n(rst_a_n), .key_in(key_in),
    .press_pulse(press[1]), .release_pulse(rel[1]), .short_pulse(shrt[1]),
    .long_pulse(lng[1]), .repeat_pulse(rep[1]), .held(hld[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks whether a press is active and how many edges
  // have elapsed since the press edge; events follow from that age.
  bit m_act[2];
  int m_age[2];
  bit m_prev[2];
  bit e_press[2], e_rel[2], e_shrt[2], e_lng[2], e_rep[2], e_hld[2];
  bit m_ren[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_age[i] = 0; m_prev[i] = 0;
      e_press[i] = 0; e_rel[i] = 0; e_shrt[i] = 0;
      e_lng[i] = 0; e_rep[i] = 0; e_hld[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic k);
    e_press[i] = 0; e_rel[i] = 0; e_shrt[i] = 0; e_lng[i] = 0; e_rep[i] = 0;
    if (!m_act[i]) begin
      if (k && !m_prev[i]) begin
        m_act[i] = 1; m_age[i] = 0; e_press[i] = 1;
      end
    end else if (!k) begin
      e_rel[i]  = 1;
      e_shrt[i] = (m_age[i] + 1 <= LONG);
      m_act[i]  = 0;
    end else begin
      m_age[i]++;
      if (m_age[i] == LONG)
        e_lng[i] = 1;
      else if (m_ren[i] && m_age[i] > LONG && ((m_age[i] - LONG) % REPEAT) == 0)
        e_rep[i] = 1;
    end
    e_hld[i]  = m_act[i];
    m_prev[i] = k;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: observed %b, expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s press[%0d]", ctx, i),   press[i], e_press[i]);
      check($sformatf("%s release[%0d]", ctx, i), rel[i],   e_rel[i]);
      check($sformatf("%s short[%0d]", ctx, i),   shrt[i],  e_shrt[i]);
      check($sformatf("%s long[%0d]", ctx, i),    lng[i],   e_lng[i]);
      check($sformatf("%s repeat[%0d]", ctx, i),  rep[i],   e_rep[i]);
      check($sformatf("%s held[%0d]", ctx, i),    hld[i],   e_hld[i]);
    end
  endtask

  // Called at a negedge: drive key, let one posedge happen, then compare.
  task automatic step(input logic k);
    key_in = k;
    @(posedge clk);
    if (rst_a_n) begin
      for (int i = 0; i < 2; i++) model_edge(i, k);
    end else begin
      model_reset();
    end
    @(negedge clk);
    check_all("edge");
  endtask

  task automatic hold_then_release(input int len);
    for (int j = 0; j < len; j++) step(1'b1);
    step(1'b0);
  endtask

  // Reset in the middle of a clock period; outputs must clear without an edge.
  task automatic async_reset();
    #2;
    rst_a_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ren[0] = 1;
    m_ren[1] = 0;
    model_reset();
    rst_a_n = 1'b0;
    key_in  = 1'b0;
    @(negedge clk);
    check_all("reset");

    // Toggle the key while in reset: nothing may come out.
    for (int j = 0; j < 4; j++) step(j[0]);
    $display("txn reset_toggle done");

    // Key held through reset release -> press on the first edge.
    key_in  = 1'b1;
    rst_a_n = 1'b1;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    $display("txn short_press_after_reset done");

    step(1'b0);
    hold_then_release(20);
    $display("txn long_hold_20 done");

    step(1'b0);
    hold_then_release(8);
    $display("txn boundary_release_at_long done");

    step(1'b0);
    hold_then_release(12);
    $display("txn release_at_repeat done");

    // Mid-hold reset, then reset removed with key low: no release appears.
    step(1'b0);
    for (int j = 0; j < 11; j++) step(1'b1);
    async_reset();
    key_in  = 1'b0;
    rst_a_n = 1'b1;
    for (int j = 0; j < 3; j++) step(1'b0);
    $display("txn mid_hold_reset done");

    hold_then_release(30);
    $display("txn long_hold_30 done");

    // Release immediately followed by a new press.
    hold_then_release(2);
    hold_then_release(1);
    $display("txn back_to_back done");

    for (int t = 0; t < 40; t++) begin
      int gap, len;
      bit do_rst;
      gap    = $urandom_range(1, 4);
      len    = $urandom_range(1, 30);
      do_rst = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < gap; j++) step(1'b0);
      if (do_rst) begin
        for (int j = 0; j < len; j++) step(1'b1);
        async_reset();
        key_in  = $urandom_range(0, 1);
        rst_a_n = 1'b1;
        step(key_in);
        step(1'b0);
      end else begin
        hold_then_release(len);
      end
      $display("txn random %0d gap=%0d hold=%0d reset=%0d", t, gap, len, do_rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
